// File: rtl/riscv_dm_pkg.sv
// Shared DMI widths, op encodings and arbiter types for the debug module slice.
package riscv_dm_pkg;

  localparam int unsigned DMI_ADDR_WIDTH = 7;
  localparam int unsigned DMI_DATA_WIDTH = 32;
  localparam int unsigned DMI_OP_WIDTH   = 2;

  localparam logic [DMI_OP_WIDTH-1:0] DTM_NOP   = 2'd0;
  localparam logic [DMI_OP_WIDTH-1:0] DTM_READ  = 2'd1;
  localparam logic [DMI_OP_WIDTH-1:0] DTM_WRITE = 2'd2;

  localparam logic [DMI_OP_WIDTH-1:0] RD_OP_SUCCESS = 2'd0;
  localparam logic [DMI_OP_WIDTH-1:0] RD_OP_FAILED  = 2'd2;
  localparam logic [DMI_OP_WIDTH-1:0] RD_OP_BUSY    = 2'd3;

  localparam int unsigned DMI_ARB_TIMEOUT_DEFAULT = 1024;

  typedef struct packed {
    logic [DMI_ADDR_WIDTH-1:0] addr;
    logic [DMI_DATA_WIDTH-1:0] data;
    logic [DMI_OP_WIDTH-1:0]   op;
  } dmi_req_t;

  typedef struct packed {
    logic [DMI_DATA_WIDTH-1:0] data;
    logic [DMI_OP_WIDTH-1:0]   op;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP,
    ARB_DELIVER
  } dmi_arb_state_t;

endpackage

// File: rtl/dmi_rr_arbiter.sv
// Combinational round-robin pick: first valid index strictly after last_i, wrapping.
module dmi_rr_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   valid_i,
  input  logic [IDX_WIDTH-1:0] last_i,
  output logic                 any_o,
  output logic [IDX_WIDTH-1:0] idx_o
);

  int unsigned          cand;
  logic [IDX_WIDTH-1:0] cand_idx;

  always_comb begin
    any_o    = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand     = (32'(last_i) + i) % NUM_REQ;
      cand_idx = IDX_WIDTH'(cand);
      if (!any_o && valid_i[cand_idx]) begin
        any_o = 1'b1;
        idx_o = cand_idx;
      end
    end
  end

endmodule

// File: rtl/dmi_arbiter.sv
// Shares one DM DMI port among NUM_REQ debug hosts, one full transaction at a time,
// with a response timeout and post-timeout drain of the late DM response.
module dmi_arbiter
  import riscv_dm_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = DMI_ARB_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_WIDTH      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                                    clk_i,
  input  logic                                    trst_i,
  input  logic [NUM_REQ-1:0]                      req_valid_i,
  output logic [NUM_REQ-1:0]                      req_ready_o,
  input  logic [NUM_REQ-1:0][DMI_ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0][DMI_DATA_WIDTH-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0][DMI_OP_WIDTH-1:0]    req_op_i,
  output logic [NUM_REQ-1:0]                      resp_valid_o,
  input  logic [NUM_REQ-1:0]                      resp_ready_i,
  output logic [DMI_DATA_WIDTH-1:0]               resp_data_o,
  output logic [DMI_OP_WIDTH-1:0]                 resp_op_o,
  output logic                                    dm_req_valid_o,
  input  logic                                    dm_req_ready_i,
  output logic [DMI_ADDR_WIDTH-1:0]               dm_req_addr_o,
  output logic [DMI_DATA_WIDTH-1:0]               dm_req_data_o,
  output logic [DMI_OP_WIDTH-1:0]                 dm_req_op_o,
  input  logic                                    dm_resp_valid_i,
  output logic                                    dm_resp_ready_o,
  input  logic [DMI_DATA_WIDTH-1:0]               dm_resp_data_i,
  input  logic [DMI_OP_WIDTH-1:0]                 dm_resp_op_i,
  input  logic                                    clear_i,
  output logic [$clog2(NUM_REQ)-1:0]              grant_o,
  output logic                                    busy_o,
  output logic                                    timeout_o
);

  localparam int unsigned IDX_WIDTH = $clog2(NUM_REQ);

  dmi_arb_state_t       state_q;
  dmi_req_t             req_q;
  dmi_resp_t            resp_q;
  logic [IDX_WIDTH-1:0] grant_q;
  logic [IDX_WIDTH-1:0] last_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 drain_q;
  logic                 timeout_q;

  logic                 rr_any;
  logic [IDX_WIDTH-1:0] rr_idx;
  logic                 pick_en;
  logic                 cnt_hit;

  dmi_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rr (
    .valid_i (req_valid_i),
    .last_i  (last_q),
    .any_o   (rr_any),
    .idx_o   (rr_idx)
  );

  assign pick_en = (state_q == ARB_IDLE) && rr_any && !drain_q;
  // The counter value is the number of completed wait cycles; the limit is hit
  // on the cycle whose increment would reach TIMEOUT_CYCLES.
  assign cnt_hit = (TIMEOUT_CYCLES != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES);

  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = '0;
    if (pick_en) req_ready_o[rr_idx] = 1'b1;
    if (state_q == ARB_DELIVER) resp_valid_o[grant_q] = 1'b1;
  end

  assign dm_req_valid_o  = (state_q == ARB_REQ);
  assign dm_req_addr_o   = req_q.addr;
  assign dm_req_data_o   = req_q.data;
  assign dm_req_op_o     = req_q.op;
  assign dm_resp_ready_o = (state_q == ARB_RESP) || drain_q;
  assign resp_data_o     = resp_q.data;
  assign resp_op_o       = resp_q.op;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q != ARB_IDLE);
  assign timeout_o       = timeout_q;

  always_ff @(posedge clk_i or posedge trst_i) begin
    if (trst_i) begin
      state_q   <= ARB_IDLE;
      req_q     <= '0;
      resp_q    <= '0;
      grant_q   <= '0;
      last_q    <= IDX_WIDTH'(NUM_REQ - 1);
      cnt_q     <= '0;
      drain_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (clear_i) begin
        drain_q   <= 1'b0;
        timeout_q <= 1'b0;
      end
      // Late response from a timed-out transaction is swallowed here.
      if (drain_q && (state_q != ARB_RESP) && dm_resp_valid_i) drain_q <= 1'b0;

      case (state_q)
        ARB_IDLE: begin
          if (pick_en) begin
            req_q   <= '{addr: req_addr_i[rr_idx], data: req_data_i[rr_idx], op: req_op_i[rr_idx]};
            grant_q <= rr_idx;
            state_q <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (dm_req_ready_i) begin
            cnt_q   <= '0;
            state_q <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (dm_resp_valid_i) begin
            resp_q  <= '{data: dm_resp_data_i, op: dm_resp_op_i};
            state_q <= ARB_DELIVER;
          end else if (cnt_hit) begin
            resp_q    <= '{data: '0, op: RD_OP_FAILED};
            timeout_q <= 1'b1;
            drain_q   <= 1'b1;
            state_q   <= ARB_DELIVER;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ARB_DELIVER: begin
          if (resp_ready_i[grant_q]) begin
            last_q  <= grant_q;
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed self-checking bench for dmi_arbiter with a short response timeout.
module tb_dmi_arbiter;
  import riscv_dm_pkg::*;

  logic                                clk_i = 1'b0;
  logic                                trst_i;
  logic [1:0]                          req_valid_i;
  logic [1:0]                          req_ready_o;
  logic [1:0][DMI_ADDR_WIDTH-1:0]      req_addr_i;
  logic [1:0][DMI_DATA_WIDTH-1:0]      req_data_i;
  logic [1:0][DMI_OP_WIDTH-1:0]        req_op_i;
  logic [1:0]                          resp_valid_o;
  logic [1:0]                          resp_ready_i;
  logic [DMI_DATA_WIDTH-1:0]           resp_data_o;
  logic [DMI_OP_WIDTH-1:0]             resp_op_o;
  logic                                dm_req_valid_o;
  logic                                dm_req_ready_i;
  logic [DMI_ADDR_WIDTH-1:0]           dm_req_addr_o;
  logic [DMI_DATA_WIDTH-1:0]           dm_req_data_o;
  logic [DMI_OP_WIDTH-1:0]             dm_req_op_o;
  logic                                dm_resp_valid_i;
  logic                                dm_resp_ready_o;
  logic [DMI_DATA_WIDTH-1:0]           dm_resp_data_i;
  logic [DMI_OP_WIDTH-1:0]             dm_resp_op_i;
  logic                                clear_i;
  logic [0:0]                          grant_o;
  logic                                busy_o;
  logic                                timeout_o;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  dmi_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i           (clk_i),
    .trst_i          (trst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_data_i      (req_data_i),
    .req_op_i        (req_op_i),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_data_o     (resp_data_o),
    .resp_op_o       (resp_op_o),
    .dm_req_valid_o  (dm_req_valid_o),
    .dm_req_ready_i  (dm_req_ready_i),
    .dm_req_addr_o   (dm_req_addr_o),
    .dm_req_data_o   (dm_req_data_o),
    .dm_req_op_o     (dm_req_op_o),
    .dm_resp_valid_i (dm_resp_valid_i),
    .dm_resp_ready_o (dm_resp_ready_o),
    .dm_resp_data_i  (dm_resp_data_i),
    .dm_resp_op_i    (dm_resp_op_i),
    .clear_i         (clear_i),
    .grant_o         (grant_o),
    .busy_o          (busy_o),
    .timeout_o       (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic test_reset();
    trst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    n_total++;
    if ({req_ready_o, resp_valid_o, dm_req_valid_o, dm_resp_ready_o, busy_o, timeout_o, grant_o} !== 9'd0)
      $display("FAIL reset_ctrl: got %b expected 0", {req_ready_o, resp_valid_o, dm_req_valid_o, dm_resp_ready_o, busy_o, timeout_o, grant_o});
    else n_pass++;
    n_total++;
    if ({dm_req_addr_o, dm_req_data_o, dm_req_op_o, resp_data_o, resp_op_o} !== '0)
      $display("FAIL reset_payload: got %h expected 0", {dm_req_addr_o, dm_req_data_o, dm_req_op_o, resp_data_o, resp_op_o});
    else n_pass++;
    @(negedge clk_i);
    trst_i = 1'b0;
  endtask

  task automatic test_single_read();
    @(negedge clk_i);
    req_valid_i = 2'b01; req_addr_i[0] = 7'h10; req_data_i[0] = '0; req_op_i[0] = DTM_READ;
    #1;
    n_total++;
    if (req_ready_o !== 2'b01) $display("FAIL single_accept: got %b expected 01", req_ready_o); else n_pass++;
    @(negedge clk_i);
    req_valid_i = 2'b00;
    #1;
    n_total++;
    if ({req_ready_o, dm_req_valid_o, dm_req_addr_o, dm_req_op_o} !== {2'b00, 1'b1, 7'h10, DTM_READ})
      $display("FAIL single_dmreq: got %b/%b/%h/%h expected 00/1/10/1", req_ready_o, dm_req_valid_o, dm_req_addr_o, dm_req_op_o);
    else n_pass++;
    dm_req_ready_i = 1'b1;
    @(negedge clk_i);
    dm_req_ready_i = 1'b0;
    @(negedge clk_i);
    dm_resp_valid_i = 1'b1; dm_resp_data_i = 32'h0000_0001; dm_resp_op_i = RD_OP_SUCCESS;
    @(negedge clk_i);
    dm_resp_valid_i = 1'b0;
    #1;
    n_total++;
    if ({resp_valid_o, resp_data_o, resp_op_o, busy_o} !== {2'b01, 32'h1, RD_OP_SUCCESS, 1'b1})
      $display("FAIL single_resp: got %b/%h/%h/%b expected 01/00000001/0/1", resp_valid_o, resp_data_o, resp_op_o, busy_o);
    else n_pass++;
    resp_ready_i = 2'b01;
    @(negedge clk_i);
    resp_ready_i = 2'b00;
    #1;
    n_total++;
    if ({busy_o, resp_valid_o} !== 3'b000) $display("FAIL single_done: got busy %b resp_valid %b expected 0/00", busy_o, resp_valid_o);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [0:0]                exp_g;
    logic [1:0]                exp_onehot;
    logic [DMI_DATA_WIDTH-1:0] rdata;
    trst_i = 1'b1;
    @(negedge clk_i);
    trst_i = 1'b0;
    req_addr_i[0] = 7'h20; req_data_i[0] = 32'hAAAA_0000; req_op_i[0] = DTM_READ;
    req_addr_i[1] = 7'h21; req_data_i[1] = 32'hBBBB_0000; req_op_i[1] = DTM_NOP;
    req_valid_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g      = 1'(k % 2);
      exp_onehot = 2'b01 << exp_g;
      rdata      = 32'hC0DE_0000 + 32'(k);
      #1;
      n_total++;
      if (req_ready_o !== exp_onehot) $display("FAIL cont_grant%0d: got %b expected %b", k, req_ready_o, exp_onehot);
      else n_pass++;
      @(negedge clk_i);
      #1;
      n_total++;
      if ({req_ready_o, dm_req_valid_o, grant_o, dm_req_addr_o, dm_req_op_o} !==
          {2'b00, 1'b1, exp_g, 7'h20 + 7'(exp_g), (exp_g == 1'b1) ? DTM_NOP : DTM_READ})
        $display("FAIL cont_req%0d: got %b/%b/%b/%h/%h expected 00/1/%b/%h", k, req_ready_o, dm_req_valid_o, grant_o,
                 dm_req_addr_o, dm_req_op_o, exp_g, 7'h20 + 7'(exp_g));
      else n_pass++;
      dm_req_ready_i = 1'b1;
      @(negedge clk_i);
      dm_req_ready_i = 1'b0;
      dm_resp_valid_i = 1'b1; dm_resp_data_i = rdata; dm_resp_op_i = RD_OP_SUCCESS;
      @(negedge clk_i);
      dm_resp_valid_i = 1'b0;
      #1;
      n_total++;
      if ({resp_valid_o, resp_data_o} !== {exp_onehot, rdata})
        $display("FAIL cont_resp%0d: got %b/%h expected %b/%h", k, resp_valid_o, resp_data_o, exp_onehot, rdata);
      else n_pass++;
      resp_ready_i = 2'b11;
      @(negedge clk_i);
      resp_ready_i = 2'b00;
    end
    req_valid_i = 2'b00;
  endtask

  task automatic test_backpressure();
    @(negedge clk_i);
    req_valid_i = 2'b10; req_addr_i[1] = 7'h33; req_data_i[1] = 32'h1234_5678; req_op_i[1] = DTM_WRITE;
    #1;
    n_total++;
    if (req_ready_o !== 2'b10) $display("FAIL bp_accept: got %b expected 10", req_ready_o); else n_pass++;
    @(negedge clk_i);
    req_valid_i = 2'b11; req_addr_i[1] = 7'h7F; req_data_i[1] = '1; req_op_i[0] = DTM_READ;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if ({req_ready_o, dm_req_valid_o, dm_req_addr_o, dm_req_data_o, dm_req_op_o} !==
          {2'b00, 1'b1, 7'h33, 32'h1234_5678, DTM_WRITE})
        $display("FAIL bp_hold%0d: got %b/%b/%h/%h/%h expected 00/1/33/12345678/2", i, req_ready_o, dm_req_valid_o,
                 dm_req_addr_o, dm_req_data_o, dm_req_op_o);
      else n_pass++;
      @(negedge clk_i);
    end
    dm_req_ready_i = 1'b1;
    @(negedge clk_i);
    dm_req_ready_i = 1'b0;
    dm_resp_valid_i = 1'b1; dm_resp_data_i = 32'h55AA_55AA; dm_resp_op_i = RD_OP_SUCCESS;
    @(negedge clk_i);
    dm_resp_valid_i = 1'b0;
    resp_ready_i = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if ({req_ready_o, resp_valid_o, resp_data_o} !== {2'b00, 2'b10, 32'h55AA_55AA})
        $display("FAIL bp_resp%0d: got %b/%b/%h expected 00/10/55aa55aa", i, req_ready_o, resp_valid_o, resp_data_o);
      else n_pass++;
      @(negedge clk_i);
    end
    resp_ready_i = 2'b10;
    @(negedge clk_i);
    resp_ready_i = 2'b00;
    req_valid_i = 2'b00;
    #1;
    n_total++;
    if (busy_o !== 1'b0) $display("FAIL bp_done: got busy %b expected 0", busy_o); else n_pass++;
  endtask

  task automatic test_timeout();
    int unsigned n;
    @(negedge clk_i);
    req_valid_i = 2'b01; req_addr_i[0] = 7'h11; req_op_i[0] = DTM_READ;
    @(negedge clk_i);
    req_valid_i = 2'b00; dm_req_ready_i = 1'b1;
    @(negedge clk_i);
    dm_req_ready_i = 1'b0;
    n = 0;
    while (resp_valid_o === 2'b00 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    #1;
    n_total++;
    if (n !== 8) $display("FAIL to_latency: got %0d cycles expected 8", n); else n_pass++;
    n_total++;
    if ({resp_valid_o, resp_data_o, resp_op_o, timeout_o} !== {2'b01, 32'h0, RD_OP_FAILED, 1'b1})
      $display("FAIL to_resp: got %b/%h/%h/%b expected 01/00000000/2/1", resp_valid_o, resp_data_o, resp_op_o, timeout_o);
    else n_pass++;
    resp_ready_i = 2'b01;
    @(negedge clk_i);
    resp_ready_i = 2'b00;
    req_valid_i = 2'b10; req_addr_i[1] = 7'h22; req_op_i[1] = DTM_READ;
    #1;
    n_total++;
    if ({req_ready_o, dm_resp_ready_o, busy_o} !== {2'b00, 1'b1, 1'b0})
      $display("FAIL to_blocked: got %b/%b/%b expected 00/1/0", req_ready_o, dm_resp_ready_o, busy_o);
    else n_pass++;
    @(negedge clk_i);
    dm_resp_valid_i = 1'b1; dm_resp_data_i = 32'hDEAD_BEEF; dm_resp_op_i = RD_OP_SUCCESS;
    @(negedge clk_i);
    dm_resp_valid_i = 1'b0;
    #1;
    n_total++;
    if ({resp_valid_o, req_ready_o, dm_resp_ready_o} !== {2'b00, 2'b10, 1'b0})
      $display("FAIL to_drain: got %b/%b/%b expected 00/10/0", resp_valid_o, req_ready_o, dm_resp_ready_o);
    else n_pass++;
    @(negedge clk_i);
    req_valid_i = 2'b00; dm_req_ready_i = 1'b1;
    #1;
    n_total++;
    if ({dm_req_valid_o, dm_req_addr_o} !== {1'b1, 7'h22})
      $display("FAIL to_next_req: got %b/%h expected 1/22", dm_req_valid_o, dm_req_addr_o);
    else n_pass++;
    @(negedge clk_i);
    dm_req_ready_i = 1'b0;
    dm_resp_valid_i = 1'b1; dm_resp_data_i = 32'h0BAD_F00D; dm_resp_op_i = RD_OP_SUCCESS;
    @(negedge clk_i);
    dm_resp_valid_i = 1'b0;
    #1;
    n_total++;
    if ({resp_valid_o, resp_data_o, resp_op_o, timeout_o} !== {2'b10, 32'h0BAD_F00D, RD_OP_SUCCESS, 1'b1})
      $display("FAIL to_next_resp: got %b/%h/%h/%b expected 10/0badf00d/0/1", resp_valid_o, resp_data_o, resp_op_o, timeout_o);
    else n_pass++;
    resp_ready_i = 2'b10;
    @(negedge clk_i);
    resp_ready_i = 2'b00;
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    #1;
    n_total++;
    if (timeout_o !== 1'b0) $display("FAIL to_clear: got %b expected 0", timeout_o); else n_pass++;
  endtask

  task automatic test_boundary();
    @(negedge clk_i);
    req_valid_i = 2'b01; req_addr_i[0] = 7'h12; req_op_i[0] = DTM_READ;
    @(negedge clk_i);
    req_valid_i = 2'b00; dm_req_ready_i = 1'b1;
    @(negedge clk_i);
    dm_req_ready_i = 1'b0;
    repeat (7) @(negedge clk_i);
    #1;
    n_total++;
    if ({resp_valid_o, busy_o} !== {2'b00, 1'b1}) $display("FAIL bnd_wait: got %b/%b expected 00/1", resp_valid_o, busy_o);
    else n_pass++;
    dm_resp_valid_i = 1'b1; dm_resp_data_i = 32'hB0DA_0008; dm_resp_op_i = RD_OP_SUCCESS;
    @(negedge clk_i);
    dm_resp_valid_i = 1'b0;
    #1;
    n_total++;
    if ({resp_valid_o, resp_data_o, resp_op_o, timeout_o} !== {2'b01, 32'hB0DA_0008, RD_OP_SUCCESS, 1'b0})
      $display("FAIL bnd_resp: got %b/%h/%h/%b expected 01/b0da0008/0/0", resp_valid_o, resp_data_o, resp_op_o, timeout_o);
    else n_pass++;
    resp_ready_i = 2'b01;
    @(negedge clk_i);
    resp_ready_i = 2'b00;
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk_i);
    req_valid_i = 2'b10; req_addr_i[1] = 7'h2A; req_op_i[1] = DTM_READ;
    @(negedge clk_i);
    req_valid_i = 2'b00; dm_req_ready_i = 1'b1;
    @(negedge clk_i);
    dm_req_ready_i = 1'b0;
    #1;
    n_total++;
    if ({busy_o, dm_resp_ready_o} !== 2'b11) $display("FAIL rst_in_resp: got %b expected 11", {busy_o, dm_resp_ready_o});
    else n_pass++;
    #1 trst_i = 1'b1;
    #1;
    n_total++;
    if ({busy_o, dm_resp_ready_o, dm_req_valid_o, resp_valid_o, grant_o, dm_req_addr_o} !== '0)
      $display("FAIL rst_async: got %b expected 0", {busy_o, dm_resp_ready_o, dm_req_valid_o, resp_valid_o, grant_o, dm_req_addr_o});
    else n_pass++;
    @(negedge clk_i);
    trst_i = 1'b0;
    req_valid_i = 2'b11;
    #1;
    n_total++;
    if (req_ready_o !== 2'b01) $display("FAIL rst_first_grant: got %b expected 01", req_ready_o); else n_pass++;
    req_valid_i = 2'b00;
    repeat (2) @(negedge clk_i);
    n_total++;
    if ({resp_valid_o, busy_o} !== 3'b000) $display("FAIL rst_no_resp: got %b expected 000", {resp_valid_o, busy_o});
    else n_pass++;
  endtask

  initial begin
    trst_i = 1'b1; req_valid_i = '0; req_addr_i = '0; req_data_i = '0; req_op_i = '0;
    resp_ready_i = '0; dm_req_ready_i = 1'b0; dm_resp_valid_i = 1'b0; dm_resp_data_i = '0;
    dm_resp_op_i = '0; clear_i = 1'b0;
    test_reset();
    test_single_read();
    test_contention();
    test_backpressure();
    test_timeout();
    test_boundary();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/dmi_arbiter.md
Name: dmi_arbiter

Overview:
Shares the single Debug Module DMI port between NUM_REQ debug hosts: requester 0 is the JTAG DTM, the rest are auxiliary hosts such as a UART or system-bus debug bridge. It grants one complete DMI transaction at a time, round-robin, latches the request, and forwards it to the DM. It then routes the DM response back to the owning requester. A response timeout prevents a hung DM from stalling every host.

Parameters:
NUM_REQ, 2, number of DMI requesters (>=2)
TIMEOUT_CYCLES, 1024, clk_i cycles to wait in RESP before synthesising a failed response; 0 disables the timeout
CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived)

Ports:
clk_i  in  1  DMI-side clock
trst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  one-cycle accept pulse to granted requester
req_addr_i  in  NUM_REQ x DMI_ADDR_WIDTH  request address
req_data_i  in  NUM_REQ x DMI_DATA_WIDTH  request write data
req_op_i  in  NUM_REQ x DMI_OP_WIDTH  request op (NOP/READ/WRITE)
resp_valid_o  out  NUM_REQ  response valid to owner
resp_ready_i  in  NUM_REQ  requester accepts response
resp_data_o  out  DMI_DATA_WIDTH  response data (shared bus, qualified by resp_valid_o)
resp_op_o  out  DMI_OP_WIDTH  response status
dm_req_valid_o  out  1  request to DM
dm_req_ready_i  in  1  DM accepts request
dm_req_addr_o  out  DMI_ADDR_WIDTH  latched address
dm_req_data_o  out  DMI_DATA_WIDTH  latched data
dm_req_op_o  out  DMI_OP_WIDTH  latched op
dm_resp_valid_i  in  1  DM response valid
dm_resp_ready_o  out  1  arbiter accepts DM response
dm_resp_data_i  in  DMI_DATA_WIDTH  DM response data
dm_resp_op_i  in  DMI_OP_WIDTH  DM response status
clear_i  in  1  clears timeout_o and drain_pending
grant_o  out  $clog2(NUM_REQ)  index of current/last owner
busy_o  out  1  state != IDLE
timeout_o  out  1  sticky: a timeout has occurred

Behaviour:
- Reset: state=IDLE, last_grant=NUM_REQ-1, grant_o=0, every valid/ready output 0, latched payload 0, counter 0, drain_pending=0, timeout_o=0. A reset mid-transaction abandons the transaction; no response is delivered.
- IDLE:
  - If any req_valid_i and !drain_pending, pick the first valid index after last_grant (round-robin, wrapping).
  - In that same cycle: assert req_ready_o[g]=1, latch addr/data/op, set grant_o=g, go to REQ.
  - No combinational path from req_valid_i to dm_req_valid_o.
- REQ:
  - dm_req_valid_o=1 with the latched payload, held stable until dm_req_ready_i.
  - On dm_req_ready_i go to RESP and clear the counter.
- RESP:
  - dm_resp_ready_o=1.
  - On dm_resp_valid_i latch data/op and go to DELIVER.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES (if nonzero): latch data=0, op=RD_OP_FAILED(2), set timeout_o=1 and drain_pending=1, go to DELIVER.
  - A DM response in the same cycle as the counter hitting the limit wins; no timeout is flagged.
- DELIVER:
  - resp_valid_o[g]=1 and all other bits 0; resp_data_o/resp_op_o hold the latched values.
  - On resp_ready_i[g]: last_grant=g, go to IDLE.
  - Ready from a non-owner is ignored.
- Drain:
  - While drain_pending and state != RESP, dm_resp_ready_o=1. The next dm_resp_valid_i is discarded and clears drain_pending.
  - clear_i also clears drain_pending and timeout_o.
  - New grants are blocked while drain_pending is set.
- Min latency, request accept to resp_valid_o: REQ 1 cycle + DM latency + 1. A back-to-back transaction from the same requester is possible only if no other requester is valid.
- A requester with op=NOP is still forwarded; the DM answers.
- RESP and DELIVER responses use the ops in riscv_dm_pkg: SUCCESS=0, FAILED=2, BUSY=3.

Decomposition:
- riscv_dm_pkg: existing DMI_*_WIDTH and RD_OP_* constants; add a dmi_req_t struct {addr,data,op}, a dmi_resp_t struct {data,op}, a dmi_arb_state_t enum {ARB_IDLE, ARB_REQ, ARB_RESP, ARB_DELIVER}, and DMI_ARB_TIMEOUT_DEFAULT.
- Sub-module dmi_rr_arbiter: combinational round-robin pick (valid vector, last_grant) -> (any, idx). Reused by other shared debug resources.

Test Plan:
- Single read: req0 valid, addr 0x10, op READ; DM ready at once, responds 2 cycles later with data 0x00000001 op 0 -> req_ready_o[0] pulses once; dm_req_* = 0x10/READ; resp_valid_o=01 with data 0x1, op 0; busy_o falls after resp_ready_i[0].
- Contention: req0 and req1 valid continuously, 4 transactions -> grant order 0,1,0,1; no dm_req_valid_o gap beyond 1 IDLE cycle; each response goes only to its owner.
- Backpressure: dm_req_ready_i low for 5 cycles, then resp_ready_i[1] low for 3 cycles -> dm_req_* stable for all 5 cycles; resp_valid_o[1] held 3 cycles with constant data; req0 not granted meanwhile.
- Timeout: TIMEOUT_CYCLES=8, DM never responds -> at 8 cycles in RESP the owner gets op 2, data 0, timeout_o=1. The next request is blocked; a late DM response 0xDEADBEEF is dropped and drain clears; the next request proceeds. clear_i then drops timeout_o.
- Boundary: DM response arrives exactly when the counter reaches 8 -> real data delivered, timeout_o stays 0.
- Reset mid-op: assert trst_i during RESP -> all outputs 0 asynchronously; after release, req0 wins first grant when both are valid.
